// File: rtl/serial_shifter32.sv
// Multi-cycle shift/rotate unit: one left-shift datapath that moves one bit per clock.
// Right-direction ops reverse the operand on entry and reverse the result on exit.
module serial_shifter32 #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               state_reg, state_next;
   logic [1:0]           op_reg, op_next;
   logic [SHAMT_W-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]     work_reg, work_next;
   logic                 fill_reg, fill_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic [WIDTH-1:0]     out_reg, out_next;

   logic [WIDTH-1:0]     rev_in;
   logic [WIDTH-1:0]     rev_work;
   logic                 shift_bit;

   // Pure wiring bit reversal, shared by operand entry and result exit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rev_in[gi]   = in[WIDTH-1-gi];
      assign rev_work[gi] = work_reg[WIDTH-1-gi];
   end

   // Bit entering at position 0 each step; in reversed space this becomes the MSB.
   always_comb begin
      shift_bit = 1'b0;
      case (op_reg)
         OP_SRA:  shift_bit = fill_reg;
         OP_ROR:  shift_bit = work_reg[WIDTH-1];
         default: shift_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      cnt_next   = cnt_reg;
      work_next  = work_reg;
      fill_next  = fill_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      out_next   = out_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               op_next    = op;
               cnt_next   = shamt;
               busy_next  = 1'b1;
               work_next  = (op == OP_SLL) ? in : rev_in;
               fill_next  = (op == OP_SRA) ? in[WIDTH-1] : 1'b0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_reg != '0) begin
               cnt_next  = cnt_reg - SHAMT_W'(1);
               work_next = {work_reg[WIDTH-2:0], shift_bit};
            end else begin
               out_next   = (op_reg == OP_SLL) ? work_reg : rev_work;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         cnt_reg   <= '0;
         work_reg  <= '0;
         fill_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         out_reg   <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         work_reg  <= work_next;
         fill_reg  <= fill_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         out_reg   <= out_next;
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign out  = out_reg;

endmodule
